// File: rtl/al_accel_imux_seq.sv
// al_accel_imux_seq: captures a 3x3 byte window in one cycle and replays it
// as three row beats (row 0, 1, 2) over a valid/ready output handshake.
// Optional feature macro: AL_ACCEL_IMUX_PREFETCH_EN adds a one-window pending
// buffer so a new window can be taken while the current one is still sending,
// giving back-to-back output at 3 cycles per window.
module al_accel_imux_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] imux_di_0_0,
  input  logic [7:0] imux_di_0_1,
  input  logic [7:0] imux_di_0_2,
  input  logic [7:0] imux_di_1_0,
  input  logic [7:0] imux_di_1_1,
  input  logic [7:0] imux_di_1_2,
  input  logic [7:0] imux_di_2_0,
  input  logic [7:0] imux_di_2_1,
  input  logic [7:0] imux_di_2_2,
  input  logic       imux_in_valid,
  output logic       imux_in_ready,
  output logic [7:0] imux_do_0,
  output logic [7:0] imux_do_1,
  output logic [7:0] imux_do_2,
  output logic [1:0] imux_sel,
  output logic       imux_out_valid,
  input  logic       imux_out_ready,
  output logic       imux_last,
  output logic       imux_busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_reg;
  logic [1:0]             row_reg;
  logic [2:0][2:0][7:0]   act_reg;
  logic [2:0][2:0][7:0]   win_in;
  logic [2:0][7:0]        row_data;
  logic                   accept;
  logic                   beat_hs;
  logic                   last_hs;

`ifdef AL_ACCEL_IMUX_PREFETCH_EN
  logic [2:0][2:0][7:0]   pend_reg;
  logic                   pend_full_reg;
`endif

  // Window bytes gathered as [row][column].
  assign win_in[0][0] = imux_di_0_0;
  assign win_in[0][1] = imux_di_0_1;
  assign win_in[0][2] = imux_di_0_2;
  assign win_in[1][0] = imux_di_1_0;
  assign win_in[1][1] = imux_di_1_1;
  assign win_in[1][2] = imux_di_1_2;
  assign win_in[2][0] = imux_di_2_0;
  assign win_in[2][1] = imux_di_2_1;
  assign win_in[2][2] = imux_di_2_2;

`ifdef AL_ACCEL_IMUX_PREFETCH_EN
  assign imux_in_ready = !pend_full_reg;
  assign imux_busy     = (state_reg == SEND) || pend_full_reg;
`else
  assign imux_in_ready = (state_reg == IDLE);
  assign imux_busy     = (state_reg == SEND);
`endif

  assign accept  = imux_in_valid && imux_in_ready;
  assign beat_hs = imux_out_valid && imux_out_ready;
  assign last_hs = beat_hs && (row_reg == 2'd2);

  // Select the active row; the default arm keeps an illegal row index silent.
  always_comb begin
    row_data = '0;
    case (row_reg)
      2'd0:    row_data = act_reg[0];
      2'd1:    row_data = act_reg[1];
      2'd2:    row_data = act_reg[2];
      default: row_data = '0;
    endcase
  end

  // Beat outputs are pure decodes of registers, forced to zero outside SEND.
  always_comb begin
    imux_out_valid = (state_reg == SEND);
    imux_sel       = 2'd0;
    imux_do_0      = 8'd0;
    imux_do_1      = 8'd0;
    imux_do_2      = 8'd0;
    imux_last      = 1'b0;
    if (state_reg == SEND) begin
      imux_sel  = row_reg;
      imux_do_0 = row_data[0];
      imux_do_1 = row_data[1];
      imux_do_2 = row_data[2];
      imux_last = (row_reg == 2'd2);
    end
  end

  // Sequencer: capture windows, step rows on handshakes, chain windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      row_reg       <= 2'd0;
      act_reg       <= '0;
`ifdef AL_ACCEL_IMUX_PREFETCH_EN
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            act_reg   <= win_in;
            row_reg   <= 2'd0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (last_hs) begin
            row_reg <= 2'd0;
`ifdef AL_ACCEL_IMUX_PREFETCH_EN
            // Pending window has priority; otherwise a window arriving on
            // this very handshake goes straight to active.
            if (pend_full_reg) begin
              act_reg       <= pend_reg;
              pend_full_reg <= 1'b0;
            end else if (accept) begin
              act_reg <= win_in;
            end else begin
              state_reg <= IDLE;
            end
`else
            state_reg <= IDLE;
`endif
          end else begin
            if (beat_hs) begin
              row_reg <= row_reg + 2'd1;
            end
`ifdef AL_ACCEL_IMUX_PREFETCH_EN
            // Mid-window arrivals park in the pending buffer.
            if (accept) begin
              pend_reg      <= win_in;
              pend_full_reg <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          row_reg   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_al_accel_imux_seq.sv
// Directed bench for al_accel_imux_seq: table-driven per-cycle vectors plus
// hand-written sequences for reset, input stall and (with
// AL_ACCEL_IMUX_PREFETCH_EN) back-to-back and same-cycle chaining.
module tb_al_accel_imux_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] di [3][3];
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] do0, do1, do2;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       last;
  logic       busy;

  int errors = 0;
  int checks = 0;

`ifdef AL_ACCEL_IMUX_PREFETCH_EN
  localparam logic IRS = 1'b1;   // in_ready while sending with pending empty
`else
  localparam logic IRS = 1'b0;
`endif

  always #5 clk = ~clk;

  al_accel_imux_seq dut (
    .clk(clk), .rst(rst),
    .imux_di_0_0(di[0][0]), .imux_di_0_1(di[0][1]), .imux_di_0_2(di[0][2]),
    .imux_di_1_0(di[1][0]), .imux_di_1_1(di[1][1]), .imux_di_1_2(di[1][2]),
    .imux_di_2_0(di[2][0]), .imux_di_2_1(di[2][1]), .imux_di_2_2(di[2][2]),
    .imux_in_valid(in_valid), .imux_in_ready(in_ready),
    .imux_do_0(do0), .imux_do_1(do1), .imux_do_2(do2),
    .imux_sel(sel), .imux_out_valid(out_valid), .imux_out_ready(out_ready),
    .imux_last(last), .imux_busy(busy)
  );

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [7:0]  base;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // Packed view: {pad, valid, sel, do0, do1, do2, last, in_ready, busy}
  function automatic logic [31:0] obs();
    return {2'b00, out_valid, sel, do0, do1, do2, last, in_ready, busy};
  endfunction

  function automatic logic [31:0] ex(input logic ev, input logic [1:0] s,
                                     input logic [7:0] b, input logic l,
                                     input logic ir, input logic bz);
    logic [7:0] b0, b1, b2;
    b0 = ev ? b : 8'h00;
    b1 = ev ? b + 8'd1 : 8'h00;
    b2 = ev ? b + 8'd2 : 8'h00;
    return {2'b00, ev, s, b0, b1, b2, l, ir, bz};
  endfunction

  task automatic set_win(input logic [7:0] base);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        di[r][c] = base + 8'(r * 3 + c);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end else begin
      $display("ok   %s: %h", nm, a);
    end
  endtask

  task automatic add(input logic iv, input logic ordy, input logic [7:0] base,
                     input logic [31:0] e, input string nm);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.base = base; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    int acc[$];
    int gap;
    set_win(8'h00);

    // Reset state
    @(negedge clk); #1;
    chk("rst_hold", obs(), ex(0, 0, 0, 0, 1, 0));
    rst = 1'b0;
    #1;
    chk("rst_release", obs(), ex(0, 0, 0, 0, 1, 0));

    // Per-cycle table; iv=0 rows carry junk data (E0) that must be ignored
    add(1, 1, 8'h01, ex(0, 0, 8'h00, 0, 1,   0), "a_accept");
    add(0, 1, 8'hE0, ex(1, 0, 8'h01, 0, IRS, 1), "a_row0");
    add(0, 1, 8'hE0, ex(1, 1, 8'h04, 0, IRS, 1), "a_row1");
    add(0, 1, 8'hE0, ex(1, 2, 8'h07, 1, IRS, 1), "a_row2");
    add(0, 1, 8'hE0, ex(0, 0, 8'h00, 0, 1,   0), "a_idle");
    add(1, 1, 8'h10, ex(0, 0, 8'h00, 0, 1,   0), "b_accept");
    add(0, 1, 8'hE0, ex(1, 0, 8'h10, 0, IRS, 1), "b_row0");
    add(0, 0, 8'hE0, ex(1, 1, 8'h13, 0, IRS, 1), "b_hold1");
    add(0, 0, 8'hE0, ex(1, 1, 8'h13, 0, IRS, 1), "b_hold2");
    add(0, 0, 8'hE0, ex(1, 1, 8'h13, 0, IRS, 1), "b_hold3");
    add(0, 0, 8'hE0, ex(1, 1, 8'h13, 0, IRS, 1), "b_hold4");
    add(0, 1, 8'hE0, ex(1, 1, 8'h13, 0, IRS, 1), "b_row1_go");
    add(0, 1, 8'hE0, ex(1, 2, 8'h16, 1, IRS, 1), "b_row2");
    add(0, 1, 8'hE0, ex(0, 0, 8'h00, 0, 1,   0), "b_idle");

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      set_win(vecs[i].base);
      #1;
      chk(vecs[i].name, obs(), vecs[i].exp);
    end

    // Reset in the middle of a window
    @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; set_win(8'h01); #1;
    @(negedge clk); in_valid = 1'b0; #1;
    @(negedge clk); #1;
    chk("r_row1", obs(), ex(1, 1, 8'h04, 0, IRS, 1));
    rst = 1'b1; #1;
    chk("r_assert", obs(), ex(0, 0, 0, 0, 1, 0));
    @(negedge clk); #1;
    chk("r_held", obs(), ex(0, 0, 0, 0, 1, 0));
    rst = 1'b0; #1;
    chk("r_release", obs(), ex(0, 0, 0, 0, 1, 0));
    @(negedge clk); #1;
    chk("r_no_resume", obs(), ex(0, 0, 0, 0, 1, 0));
    in_valid = 1'b1; set_win(8'h20);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("r_new_row0", obs(), ex(1, 0, 8'h20, 0, IRS, 1));
    repeat (3) @(negedge clk);
    #1;
    chk("r_new_done", obs(), ex(0, 0, 0, 0, 1, 0));

`ifndef AL_ACCEL_IMUX_PREFETCH_EN
    // Input held valid through SEND: second accept exactly 4 cycles later
    @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; set_win(8'h30);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid) chk("stall_ready", {31'd0, in_ready}, 32'd0);
      if (in_ready) acc.push_back(c);
      if (acc.size() == 2) break;
      @(negedge clk);
      if (acc.size() == 1) set_win(8'h40);
    end
    gap = (acc.size() == 2) ? acc[1] - acc[0] : -1;
    chk("stall_gap", gap, 32'd4);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("stall_w2_row0", obs(), ex(1, 0, 8'h40, 0, 0, 1));
    repeat (3) @(negedge clk);
`else
    // Three windows offered back to back: nine contiguous beats
    begin
      int beat_cyc[$];
      logic [1:0] beat_sel[$];
      logic [7:0] beat_d0[$];
      logic [7:0] bases [3];
      int n_acc;
      bases[0] = 8'h50; bases[1] = 8'h60; bases[2] = 8'h70;
      n_acc = 0;
      @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; set_win(bases[0]);
      for (int c = 0; c < 20; c++) begin
        #1;
        if (out_valid) begin
          beat_cyc.push_back(c); beat_sel.push_back(sel); beat_d0.push_back(do0);
        end
        if (in_valid && in_ready) n_acc++;
        @(negedge clk);
        if (n_acc >= 3) in_valid = 1'b0;
        else set_win(bases[n_acc]);
      end
      chk("b2b_count", beat_cyc.size(), 32'd9);
      for (int k = 0; k < 9 && k < beat_cyc.size(); k++) begin
        chk($sformatf("b2b_sel%0d", k), {30'd0, beat_sel[k]}, k % 3);
        chk($sformatf("b2b_d0_%0d", k), {24'd0, beat_d0[k]},
            {24'd0, bases[k / 3] + 8'(3 * (k % 3))});
        chk($sformatf("b2b_cyc%0d", k), beat_cyc[k] - beat_cyc[0], k);
      end
    end

    // New window accepted on the row-2 handshake with pending empty
    @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; set_win(8'h80); #1;
    @(negedge clk); in_valid = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); in_valid = 1'b1; set_win(8'h90); #1;
    chk("sim_row2", obs(), ex(1, 2, 8'h86, 1, 1, 1));
    @(negedge clk); in_valid = 1'b0; #1;
    chk("sim_new_row0", obs(), ex(1, 0, 8'h90, 0, 1, 1));
    repeat (3) @(negedge clk);
`endif

    #1;
    chk("final_idle", obs(), ex(0, 0, 0, 0, 1, 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/al_accel_imux_seq.md
AL_ACCEL_IMUX_SEQ -- requirements
Module: al_accel_imux_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL expose clk  input  1  rising-edge clock for all state.
REQ-003 SHALL expose rst  input  1  asynchronous active-high reset.
REQ-004 SHALL expose imux_di_R_C (R,C in 0..2)  input  8 each  3x3 window bytes, row R, column C.
REQ-005 SHALL expose imux_in_valid  input  1  window presented on imux_di_*.
REQ-006 SHALL expose imux_in_ready  output  1  block accepts the window this cycle.
REQ-007 SHALL expose imux_do_0, imux_do_1, imux_do_2  output  8 each  columns 0..2 of the current row.
REQ-008 SHALL expose imux_sel  output  2  row index of the current beat (0..2).
REQ-009 SHALL expose imux_out_valid  input/output pair: imux_out_valid output 1, imux_out_ready input 1; beat handshake.
REQ-010 SHALL expose imux_last  output  1  high on the row-2 beat.
REQ-011 SHALL expose imux_busy  output  1  high when any window is held (active or pending).

Function
REQ-012 SHALL accept a window when imux_in_valid && imux_in_ready, capturing all nine bytes in one cycle.
REQ-013 SHALL implement states IDLE and SEND; IDLE -> SEND on accept; SEND -> IDLE on the row-2 beat handshake with no further window available.
REQ-014 SHALL assert imux_out_valid in SEND only; first beat valid the cycle after accept (latency 1).
REQ-015 SHALL drive imux_do_C = active row[imux_sel] column C, and imux_sel = row counter, while imux_out_valid is high.
REQ-016 SHALL drive imux_do_*, imux_sel and imux_last to 0 while imux_out_valid is low.
REQ-017 SHALL hold all outputs stable while imux_out_valid && !imux_out_ready (no data change under backpressure).
REQ-018 SHALL advance the row counter 0->1->2 only on a beat handshake, and reset it to 0 on the row-2 handshake.
REQ-019 SHALL never emit row values outside 0..2; rows are always emitted in order 0, 1, 2.
REQ-020 SHALL ignore imux_di_* whenever no accept occurs.

Reset
REQ-021 SHALL, on rst asserted (any cycle, including mid-window), force state IDLE, row counter 0, pending buffer empty, all data registers 0.
REQ-022 SHALL drive imux_out_valid=0, imux_last=0, imux_busy=0, imux_sel=0, imux_do_*=0 during reset; imux_in_ready=1 in the first cycle after reset release.
REQ-023 SHALL discard any partially sent window on reset; no beat of it is emitted afterwards.

Configuration
REQ-024 SHALL, with AL_ACCEL_IMUX_PREFETCH_EN undefined, drive imux_in_ready = (state == IDLE); a window costs 4 cycles minimum (accept + 3 beats).
REQ-025 SHALL, with AL_ACCEL_IMUX_PREFETCH_EN defined, add a one-window pending buffer, with imux_in_ready = !pending_full.
REQ-026 SHALL, with prefetch, on the row-2 handshake load the pending window (or a window accepted the same cycle) into the active registers, stay in SEND, row=0; sustained throughput 3 cycles per window.
REQ-027 SHALL, with prefetch, accept in IDLE directly into the active registers, leaving pending empty.
REQ-028 SHALL, with prefetch and pending full, deassert imux_in_ready until the pending window moves to active.

Verification
REQ-029 SHALL check single window: di_R_C = 8'h(R*3+C+1), ready held 1 -> beats sel=0 {01,02,03}, sel=1 {04,05,06}, sel=2 {07,08,09} last=1, cycles 1..3 after accept, then IDLE.
REQ-030 SHALL check backpressure: imux_out_ready=0 for 4 cycles on sel=1 -> do_*=04,05,06 and sel=1 held, no row skipped.
REQ-031 SHALL check reset mid-window: rst pulsed during the sel=1 beat -> out_valid=0 same cycle, all outputs 0, next window starts at sel=0.
REQ-032 SHALL check no-prefetch input stall: in_valid held high through SEND -> in_ready=0 until IDLE, second window accepted exactly 4 cycles after first.
REQ-033 SHALL check prefetch back-to-back (macro defined): 3 windows offered continuously, ready=1 -> 9 contiguous beats, sel 0,1,2,0,1,2,0,1,2, no bubbles.
REQ-034 SHALL check simultaneous event (macro defined): new window accepted on the row-2 handshake with pending empty -> next cycle sel=0 with the new window's row 0.
